// File: rtl/loader_address_sequencer_pkg.sv
// Shared types and constants for the loader address sequencer (package loader_pkg).
// Optional behaviour elsewhere is selected with the LOADER_SEQ_GAP_EN macro.
package loader_pkg;

  // Sequencer states; ST_GAP is only entered when LOADER_SEQ_GAP_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

  localparam int DEFAULT_ADDRESS_SIZE = 10;
  localparam int DEFAULT_DATA_SIZE    = 8;

  // Words per frame for NB_MSB bits split into NB_STROBE-bit loader words;
  // a non-zero remainder needs one extra, partially filled word.
  function automatic int calc_total_words(input int nb_msb, input int nb_strobe);
    int words;
    words = nb_msb / nb_strobe;
    if ((nb_msb % nb_strobe) != 0) words = words + 1;
    return words;
  endfunction

endpackage

// File: rtl/loader_address_sequencer_if.sv
// Source/loader-side signal bundle for the loader address sequencer.
//
// Handshake: a word transfers on a rising CLK edge where VALID_IN and READY_OUT
// are both high. READY_OUT depends only on sequencer state and ABORT, never on
// VALID_IN, so the source may hold VALID_IN and DATA_IN until it sees READY_OUT.
// ENABLE qualifies ADDRESS/DATA_OUT for exactly the cycles it is high; the loader
// has no backpressure.
interface loader_address_sequencer_if #(
  parameter int ADDRESS_SIZE = loader_pkg::DEFAULT_ADDRESS_SIZE,
  parameter int DATA_SIZE    = loader_pkg::DEFAULT_DATA_SIZE
);
  logic                    START;
  logic                    ABORT;
  logic                    VALID_IN;
  logic [DATA_SIZE-1:0]    DATA_IN;
  logic                    READY_OUT;
  logic [ADDRESS_SIZE-1:0] ADDRESS;
  logic                    ENABLE;
  logic [DATA_SIZE-1:0]    DATA_OUT;
  logic                    BUSY;
  logic                    DONE;

  // Controller / source side.
  modport master (
    output START, ABORT, VALID_IN, DATA_IN,
    input  READY_OUT, ADDRESS, ENABLE, DATA_OUT, BUSY, DONE
  );

  // Sequencer side.
  modport slave (
    input  START, ABORT, VALID_IN, DATA_IN,
    output READY_OUT, ADDRESS, ENABLE, DATA_OUT, BUSY, DONE
  );
endinterface

// File: rtl/loader_address_sequencer_word.sv
// Word counter for the loader address sequencer: clear, increment and a
// terminal-count flag raised when the count reaches TOTAL_WORDS-1.
module loader_word_counter #(
  parameter int WIDTH       = 10,
  parameter int TOTAL_WORDS = 11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL_WORDS - 1);

  // Count accepted words; clear wins, and the count parks at the last index
  // rather than wrapping, so it only restarts on the next frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/loader_address_sequencer.sv
// Loader address sequencer: numbers the words of one frame 0..TOTAL_WORDS-1 and
// emits one registered ADDRESS/ENABLE/DATA_OUT beat per accepted word, with a
// one-cycle DONE pulse on the last beat. One frame per START; ABORT cancels.
// Define LOADER_SEQ_GAP_EN to insert one idle GAP cycle after every non-last
// word so each beat gets its own ENABLE rising edge (1 word / 2 cycles).
// STATE exposes the FSM state for debug.
module loader_address_sequencer
  import loader_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
  parameter int TOTAL_WORDS  = 11
) (
  input  logic                       CLK,
  input  logic                       RESET,
  loader_address_sequencer_if.slave  bus,
  output loader_state_t              STATE
);

  // A frame must have at least one word and every index must fit in ADDRESS.
  if (TOTAL_WORDS < 1 || longint'(TOTAL_WORDS) > (longint'(1) << ADDRESS_SIZE)) begin : g_bad_total_words
    $error("loader_address_sequencer: TOTAL_WORDS=%0d out of range 1..2**%0d",
           TOTAL_WORDS, ADDRESS_SIZE);
  end

  loader_state_t           state_q;
  logic [ADDRESS_SIZE-1:0] address_q;
  logic [DATA_SIZE-1:0]    data_q;
  logic                    enable_q;
  logic                    done_q;

  logic [ADDRESS_SIZE-1:0] count;
  logic                    terminal;
  logic                    ready;
  logic                    accept;
  logic                    clear;

  // ABORT forces READY_OUT low so a word can never be taken in an aborted cycle.
  assign ready  = (state_q == ST_RUN) && !bus.ABORT;
  assign accept = bus.VALID_IN && ready;
  assign clear  = bus.ABORT || ((state_q == ST_IDLE) && bus.START);

  loader_word_counter #(
    .WIDTH       (ADDRESS_SIZE),
    .TOTAL_WORDS (TOTAL_WORDS)
  ) u_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (clear),
    .inc      (accept),
    .count    (count),
    .terminal (terminal)
  );

  // Frame FSM with registered beat outputs; ABORT overrides everything else.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      address_q <= '0;
      data_q    <= '0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.ABORT) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          if (bus.START) state_q <= ST_RUN;
        end
        ST_RUN: begin
          done_q <= 1'b0;
          if (accept) begin
            address_q <= count;
            data_q    <= bus.DATA_IN;
            enable_q  <= 1'b1;
            if (terminal) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
`ifdef LOADER_SEQ_GAP_EN
              state_q <= ST_GAP;
`else
              state_q <= ST_RUN;
`endif
            end
          end else begin
            enable_q <= 1'b0;
          end
        end
        ST_GAP: begin
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= ST_RUN;
        end
        ST_DONE: begin
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.READY_OUT = ready;
  assign bus.ADDRESS   = address_q;
  assign bus.ENABLE    = enable_q;
  assign bus.DATA_OUT  = data_q;
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.DONE      = done_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_loader_address_sequencer.sv
// Testbench for loader_address_sequencer: table-driven frames (continuous and
// backpressured source) plus hand sequences for abort, mid-frame reset and a
// single-word frame. Works with or without LOADER_SEQ_GAP_EN.
module tb_loader_address_sequencer;
  import loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int TW = 11;
`ifdef LOADER_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  loader_address_sequencer_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();
  loader_address_sequencer_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus1 ();
  loader_state_t state;
  loader_state_t state1;

  loader_address_sequencer #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TOTAL_WORDS(TW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .STATE (state)
  );

  loader_address_sequencer #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TOTAL_WORDS(1)) dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1),
    .STATE (state1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          start;
    logic          abort;
    logic          valid;
    logic [DW-1:0] din;
    logic          exp_ready;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dout;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic a, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    bus.START    = s;
    bus.ABORT    = a;
    bus.VALID_IN = v;
    bus.DATA_IN  = d;
  endtask

  // Expected frame: START row, then one row per cycle under the VALID_IN pattern
  // until TW words are taken, then a DONE-cycle row (START there is ignored) and
  // one IDLE row. Expected outputs are those seen just after the row's edge.
  task automatic build_frame(input logic [63:0] pat, input logic [DW-1:0] base);
    vec_t v;
    int   w;
    int   k;
    bit   gap_next;
    bit   acc;
    w = 0;
    k = 0;
    gap_next = 1'b0;
    v = '{start: 1'b1, abort: 1'b0, valid: 1'b0, din: '0, exp_ready: 1'b0, exp_en: 1'b0,
          exp_addr: last_addr, exp_dout: last_dout, exp_busy: 1'b1, exp_done: 1'b0};
    vecs.push_back(v);
    while (w < TW && k < 64) begin
      v.start     = 1'b0;
      v.valid     = pat[k];
      v.din       = v.valid ? DW'(int'(base) + w) : DW'(8'h5A ^ k);
      v.exp_ready = !gap_next;
      acc         = v.valid && v.exp_ready;
      v.exp_en    = acc;
      if (acc) begin
        last_addr = AW'(w);
        last_dout = v.din;
        exp_q.push_back(v.din);
      end
      v.exp_addr = last_addr;
      v.exp_dout = last_dout;
      v.exp_busy = 1'b1;
      v.exp_done = acc && (w == TW - 1);
      if (acc) begin
        w++;
        gap_next = GAP_EN && (w < TW);
      end else begin
        gap_next = 1'b0;
      end
      vecs.push_back(v);
      k++;
    end
    v = '{start: 1'b1, abort: 1'b0, valid: 1'b1, din: 8'hEE, exp_ready: 1'b0, exp_en: 1'b0,
          exp_addr: last_addr, exp_dout: last_dout, exp_busy: 1'b0, exp_done: 1'b0};
    vecs.push_back(v);
    v.start = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].valid, vecs[i].din);
      #1;
      check($sformatf("%s[%0d] ready", tag, i), bus.READY_OUT, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] enable", tag, i), bus.ENABLE, vecs[i].exp_en);
      check($sformatf("%s[%0d] address", tag, i), bus.ADDRESS, vecs[i].exp_addr);
      check($sformatf("%s[%0d] data_out", tag, i), bus.DATA_OUT, vecs[i].exp_dout);
      check($sformatf("%s[%0d] busy", tag, i), bus.BUSY, vecs[i].exp_busy);
      check($sformatf("%s[%0d] done", tag, i), bus.DONE, vecs[i].exp_done);
      if (bus.ENABLE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s[%0d] scoreboard: unexpected beat data %0h, no word expected", tag, i, bus.DATA_OUT);
        end else begin
          check($sformatf("%s[%0d] scoreboard", tag, i), bus.DATA_OUT, exp_q.pop_front());
        end
      end
    end
    vecs.delete();
    check($sformatf("%s missing beats", tag), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit got;
    bus.START = 1'b0;  bus.ABORT = 1'b0;  bus.VALID_IN = 1'b0;  bus.DATA_IN = '0;
    bus1.START = 1'b0; bus1.ABORT = 1'b0; bus1.VALID_IN = 1'b0; bus1.DATA_IN = '0;

    // Power-on reset.
    #2 rst = 1'b1;
    #1;
    check("reset enable", bus.ENABLE, 0);
    check("reset address", bus.ADDRESS, 0);
    check("reset data_out", bus.DATA_OUT, 0);
    check("reset busy", bus.BUSY, 0);
    check("reset done", bus.DONE, 0);
    check("reset ready", bus.READY_OUT, 0);
    check("reset state", 32'(state), 32'(ST_IDLE));
    check("reset tw1 busy", bus1.BUSY, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Table-driven frames: continuous source, then a backpressured one.
    last_addr = '0;
    last_dout = '0;
    build_frame({64{1'b1}}, 8'hA0);
    run_vectors("full");
    build_frame(64'hB4D2_9A63_5C1E_7F08, 8'h40);
    run_vectors("bp");

    // ABORT exactly when word 3 would be accepted.
    drive(1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      drive(1'b0, 1'b0, 1'b1, DW'(8'h10 + c));
      @(posedge clk);
      #1;
      if (bus.ENABLE === 1'b1 && bus.ADDRESS === AW'(2)) got = 1'b1;
    end
    check("abort reached word 2", got, 1);
    if (GAP_EN) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
    end
    drive(1'b0, 1'b1, 1'b1, 8'h99);
    #1;
    check("abort ready forced low", bus.READY_OUT, 0);
    @(posedge clk);
    #1;
    check("abort enable", bus.ENABLE, 0);
    check("abort busy", bus.BUSY, 0);
    check("abort done", bus.DONE, 0);
    check("abort address hold", bus.ADDRESS, 2);
    check("abort state", 32'(state), 32'(ST_IDLE));
    drive(1'b0, 1'b0, 1'b1, 8'h98);
    @(posedge clk);
    #1;
    check("post-abort enable", bus.ENABLE, 0);
    check("post-abort busy", bus.BUSY, 0);
    drive(1'b1, 1'b0, 1'b1, 8'h55);
    @(posedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    @(posedge clk);
    #1;
    check("restart enable", bus.ENABLE, 1);
    check("restart address", bus.ADDRESS, 0);
    check("restart data_out", bus.DATA_OUT, 8'h77);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    check("restart abort busy", bus.BUSY, 0);

    // Asynchronous reset in the middle of word 5.
    drive(1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      drive(1'b0, 1'b0, 1'b1, DW'(8'hC0 + c));
      @(posedge clk);
      #1;
      if (bus.ENABLE === 1'b1 && bus.ADDRESS === AW'(4)) got = 1'b1;
    end
    check("rst reached word 4", got, 1);
    drive(1'b0, 1'b0, 1'b1, 8'hCF);
    #2 rst = 1'b1;
    #1;
    check("async rst enable", bus.ENABLE, 0);
    check("async rst address", bus.ADDRESS, 0);
    check("async rst data_out", bus.DATA_OUT, 0);
    check("async rst busy", bus.BUSY, 0);
    check("async rst ready", bus.READY_OUT, 0);
    check("async rst done", bus.DONE, 0);
    @(negedge clk) rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'hCE);
    @(posedge clk);
    #1;
    check("after rst busy", bus.BUSY, 0);
    check("after rst enable", bus.ENABLE, 0);
    check("after rst state", 32'(state), 32'(ST_IDLE));
    drive(1'b0, 1'b0, 1'b0, '0);

    // Single-word frame on the TOTAL_WORDS=1 instance.
    @(negedge clk);
    bus1.START = 1'b1;
    #1;
    check("tw1 idle ready", bus1.READY_OUT, 0);
    @(posedge clk);
    #1;
    check("tw1 start busy", bus1.BUSY, 1);
    check("tw1 start enable", bus1.ENABLE, 0);
    @(negedge clk);
    bus1.START = 1'b0; bus1.VALID_IN = 1'b1; bus1.DATA_IN = 8'h3C;
    #1;
    check("tw1 run ready", bus1.READY_OUT, 1);
    @(posedge clk);
    #1;
    check("tw1 beat enable", bus1.ENABLE, 1);
    check("tw1 beat address", bus1.ADDRESS, 0);
    check("tw1 beat data_out", bus1.DATA_OUT, 8'h3C);
    check("tw1 beat done", bus1.DONE, 1);
    check("tw1 beat state", 32'(state1), 32'(ST_DONE));
    @(negedge clk);
    bus1.START = 1'b1; bus1.DATA_IN = 8'hC3;
    #1;
    check("tw1 done ready", bus1.READY_OUT, 0);
    @(posedge clk);
    #1;
    check("tw1 after done enable", bus1.ENABLE, 0);
    check("tw1 after done done", bus1.DONE, 0);
    check("tw1 after done busy", bus1.BUSY, 0);
    @(negedge clk);
    bus1.START = 1'b0;
    @(posedge clk);
    #1;
    check("tw1 start in done ignored", bus1.BUSY, 0);
    check("tw1 idle enable", bus1.ENABLE, 0);
    bus1.VALID_IN = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loader_address_sequencer.md
Name: loader_address_sequencer

Overview:
- Upstream stage of the MSB strobe loader.
- Accepts a stream of data words from a source over a valid/ready handshake and numbers them 0..TOTAL_WORDS-1.
- For each accepted word, presents one registered ADDRESS/ENABLE/DATA_OUT beat to the loader, then flags frame completion.
- One frame per START.

Parameters:
ADDRESS_SIZE, 10, width of ADDRESS and internal word counter
DATA_SIZE, 8, width of DATA_IN/DATA_OUT (one loader word)
TOTAL_WORDS, 11, words per frame; legal range 1..2**ADDRESS_SIZE

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  begin a frame; sampled only in IDLE
ABORT  input  1  synchronous frame cancel; highest priority
VALID_IN  input  1  source has a word on DATA_IN
DATA_IN  input  DATA_SIZE  source word
READY_OUT  output  1  sequencer accepts DATA_IN this cycle
ADDRESS  output  ADDRESS_SIZE  word index to loader, registered
ENABLE  output  1  ADDRESS/DATA_OUT beat valid, registered
DATA_OUT  output  DATA_SIZE  registered copy of accepted word
BUSY  output  1  frame in progress (state != IDLE)
DONE  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, ADDRESS=0, ENABLE=0, DATA_OUT=0, DONE=0. READY_OUT=0 and BUSY=0 because both decode from state.
- States:
  - IDLE: START=1 -> RUN, counter<=0.
  - RUN: READY_OUT=1 combinationally.
  - DONE: lasts one cycle, then -> IDLE.
  - GAP: exists only with the optional feature.
- Accept = VALID_IN & READY_OUT.
  - On accept: ADDRESS<=counter, DATA_OUT<=DATA_IN, ENABLE<=1, counter<=counter+1.
  - Latency: accept at cycle N -> ENABLE/ADDRESS visible at cycle N+1.
- In RUN without accept: ENABLE<=0. ADDRESS and DATA_OUT hold their last value.
- Last word: accept with counter==TOTAL_WORDS-1 -> DONE state.
  - DONE output=1 during the DONE state cycle, which is the same cycle as the last ENABLE beat.
  - The counter does not wrap past TOTAL_WORDS-1 within a frame. It reloads to 0 on the next START.
- In DONE and IDLE: READY_OUT=0, ENABLE<=0 at the following edge.
- START outside IDLE is ignored. START in the DONE cycle is ignored; a new frame needs START in IDLE, so frames are back-to-back with a minimum 1 idle cycle.
- ABORT=1 in any state:
  - next state IDLE, ENABLE<=0, counter<=0, no DONE pulse, READY_OUT forced 0 that cycle so no accept.
  - ABORT beats START and accept in the same cycle.
- TOTAL_WORDS=1: first accept goes directly RUN -> DONE.
- VALID_IN while not in RUN is not accepted; DATA_IN is ignored.
- Counter arithmetic is unsigned, ADDRESS_SIZE wide. Parameter check (elaboration-time error) if TOTAL_WORDS > 2**ADDRESS_SIZE or TOTAL_WORDS == 0.

Optional Feature:
- Macro: LOADER_SEQ_GAP_EN.
- Defined:
  - After every accept that is not the last word, RUN -> GAP for exactly one cycle, then GAP -> RUN.
  - In GAP: READY_OUT=0 and ENABLE<=0, so ENABLE returns low between beats and each word produces a distinct ENABLE edge for edge-sensitive consumers.
  - Peak throughput is 1 word / 2 cycles.
  - ABORT in GAP -> IDLE.
- Not defined: no GAP state. Back-to-back accepts give ENABLE continuously high, with ADDRESS incrementing every cycle at 1 word/cycle.

Decomposition:
- Shared package loader_pkg:
  - state typedef (IDLE, RUN, GAP, DONE)
  - default ADDRESS_SIZE / DATA_SIZE constants
  - function computing TOTAL_WORDS from NB_MSB / NB_STROBE / remainder, for the top level to pass in
- One sub-module is natural: loader_word_counter, with clear, increment and terminal-count flag (count==TOTAL_WORDS-1).
- FSM, output registers and handshake stay in loader_address_sequencer.

Test Plan:
- Reset mid-frame: RESET pulse at word 5 of 11 -> all outputs 0 immediately (async). After release, BUSY=0 and IDLE.
- Full frame, VALID_IN held 1, gap off:
  - START, then 11 accepts -> ENABLE high 11 consecutive cycles with ADDRESS 0..10 and DATA_OUT matching DATA_IN.
  - DONE=1 exactly in the ADDRESS=10 cycle, then BUSY=0.
- Backpressure from source: VALID_IN random 50% -> ENABLE only the cycle after each accept, ADDRESS strictly 0,1,2..10 without skips, DONE once.
- ABORT at the accept of word 3 -> that word not accepted, ENABLE=0 next cycle, no DONE. New START restarts at ADDRESS=0.
- TOTAL_WORDS=1: START, VALID_IN=1 -> single ENABLE beat ADDRESS=0 with DONE=1 the same cycle. START during DONE is ignored.
- LOADER_SEQ_GAP_EN defined, VALID_IN=1:
  - ENABLE pattern 1,0,1,0,... for 11 beats, with READY_OUT low in each GAP cycle.
  - Frame ends at cycle 21 after START, with DONE at the ADDRESS=10 beat.
